mem_arbiter: RTL and testbench

Two-to-one arbiter between the instruction cache and the data cache and the single shared 128-bit memory port. It sits directly downstream of both cache instances and upstream of the memory model.
Each cache sees a private memory port with the standard cache-side handshake: request held until mem_ready, with data consumed on the following cycle.
The arbiter serialises transactions, applies round-robin fairness, and buffers read data for one cycle so the requesting cache sees stable data.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encoding and grant identifiers for the I/D-cache
// memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } grant_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the side that
// was not granted last time wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,     // req[0] = I-cache, req[1] = D-cache
  input  grant_id_t  last,
  output grant_id_t  winner
);

  always_comb begin
    winner = IC;
    if (req == 2'b11) begin
      winner = (last == IC) ? DC : IC;
    end else if (req[1]) begin
      winner = DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache block transactions onto one memory port
// with round-robin fairness and a one-cycle release gap between grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              proc_reset,

  input  logic              ic_mem_read,
  input  logic              ic_mem_write,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  input  logic [DATA_W-1:0] ic_mem_wdata,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,

  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state, state_nxt;
  grant_id_t         last_grant, winner;
  logic [DATA_W-1:0] rdata_q;
  logic              ic_req, dc_req;
  logic              granted;

  assign ic_req  = ic_mem_read | ic_mem_write;
  assign dc_req  = dc_mem_read | dc_mem_write;
  assign granted = (state == GRANT_I) || (state == GRANT_D);

  rr_pick2 u_pick (
    .req    ({dc_req, ic_req}),
    .last   (last_grant),
    .winner (winner)
  );

  // NOTE: reset is synchronous (sampled only on the clock edge), and all
  // state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= DC;
      rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (ic_req || dc_req)) begin
        last_grant <= winner;
      end
      // mem_read is already qualified by write priority, so an illegal
      // read+write never overwrites the held read data.
      if (granted && mem_ready && mem_read) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_mem_ready = 1'b0;
    dc_mem_ready = 1'b0;

    case (state)
      IDLE: begin
        if (ic_req || dc_req) begin
          state_nxt = (winner == DC) ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I: begin
        mem_write    = ic_mem_write;
        mem_read     = ic_mem_read & ~ic_mem_write;
        mem_addr     = ic_mem_addr;
        mem_wdata    = ic_mem_wdata;
        ic_mem_ready = mem_ready;
        if (mem_ready) state_nxt = RELEASE;
      end
      GRANT_D: begin
        mem_write    = dc_mem_write;
        mem_read     = dc_mem_read & ~dc_mem_write;
        mem_addr     = dc_mem_addr;
        mem_wdata    = dc_mem_wdata;
        dc_mem_ready = mem_ready;
        if (mem_ready) state_nxt = RELEASE;
      end
      // Absorbs the cache's final request cycle after its ready pulse.
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ic_mem_rdata = rdata_q;
  assign dc_mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner sequences and
// randomized dual-cache traffic against a memory model and fairness rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [127:0] DEAD = {8{16'hDEAD}};

  logic              clk = 1'b0;
  logic              proc_reset = 1'b1;
  logic              ic_mem_read = 1'b0, ic_mem_write = 1'b0;
  logic [ADDR_W-1:0] ic_mem_addr = '0;
  logic [DATA_W-1:0] ic_mem_wdata = '0;
  logic [DATA_W-1:0] ic_mem_rdata;
  logic              ic_mem_ready;
  logic              dc_mem_read = 1'b0, dc_mem_write = 1'b0;
  logic [ADDR_W-1:0] dc_mem_addr = '0;
  logic [DATA_W-1:0] dc_mem_wdata = '0;
  logic [DATA_W-1:0] dc_mem_rdata;
  logic              dc_mem_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .ic_mem_read  (ic_mem_read),
    .ic_mem_write (ic_mem_write),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_wdata (ic_mem_wdata),
    .ic_mem_rdata (ic_mem_rdata),
    .ic_mem_ready (ic_mem_ready),
    .dc_mem_read  (dc_mem_read),
    .dc_mem_write (dc_mem_write),
    .dc_mem_addr  (dc_mem_addr),
    .dc_mem_wdata (dc_mem_wdata),
    .dc_mem_rdata (dc_mem_rdata),
    .dc_mem_ready (dc_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  typedef struct {
    logic              id;
    logic [ADDR_W-1:0] addr;
  } log_t;

  typedef struct {
    logic              id;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              exp_read;
    logic              exp_write;
  } vec_t;

  txn_t ic_q[$], dc_q[$];
  log_t done_log[$];

  // Backing store: written blocks are remembered, untouched blocks read a
  // fixed address-derived pattern.
  logic [DATA_W-1:0] mem_store [logic [ADDR_W-1:0]];

  function automatic logic [127:0] lookup(input logic [ADDR_W-1:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {a ^ 28'h5A5A5A5, 4'h1, a, 4'h2, ~a, 4'h3, a, 4'h4};
  endfunction

  // Memory: ready rises after cur_lat cycles of a held request, one-cycle pulse.
  int   mem_lat = 2;
  bit   rand_lat = 1'b0;
  int   cnt = 0;
  int   cur_lat = 2;
  logic nxt_ready = 1'b0;
  logic [DATA_W-1:0] nxt_rdata = '0;

  initial forever begin
    @(posedge clk);
    if (proc_reset || mem_ready) begin
      nxt_ready = 1'b0;
      cnt = 0;
    end else if (mem_read || mem_write) begin
      if (cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      cnt++;
      if (cnt >= cur_lat) begin
        nxt_ready = 1'b1;
        nxt_rdata = mem_write ? '0 : lookup(mem_addr);
      end
    end
    #1;
    mem_ready = nxt_ready;
    mem_rdata = nxt_rdata;
  end

  // Monitor: fairness rule, release gap, ready routing and scoreboard.
  logic prev_active = 1'b0, prev_done = 1'b0;
  logic prev_ic_req = 1'b0, prev_dc_req = 1'b0;
  logic pend_valid = 1'b0, pend_both = 1'b0, pend_sole = 1'b0;
  logic last_w = 1'b1;
  logic active, w, exp_w;
  txn_t h;

  initial forever begin
    @(negedge clk);
    #1;
    active = mem_read | mem_write;
    if (proc_reset) begin
      last_w = 1'b1;
      pend_valid = 1'b0;
      prev_done = 1'b0;
      ic_q.delete();
      dc_q.delete();
    end else begin
      if (prev_done)
        check("release_idle", 128'({mem_read, mem_write, |mem_addr, |mem_wdata,
                                    ic_mem_ready, dc_mem_ready}), '0);
      if (active && !prev_active) begin
        pend_valid = 1'b1;
        pend_both  = prev_ic_req & prev_dc_req;
        pend_sole  = prev_dc_req;
      end
      if (mem_ready && active) begin
        w = dc_mem_ready;
        check("ready_onehot", 128'(ic_mem_ready ^ dc_mem_ready), 128'(1));
        if (pend_valid) begin
          exp_w = pend_both ? ~last_w : pend_sole;
          check("rr_winner", 128'(w), 128'(exp_w));
        end
        last_w = w;
        pend_valid = 1'b0;
        if ((w && dc_q.size() == 0) || (!w && ic_q.size() == 0)) begin
          check("sb_unexpected", 128'(1), 128'(0));
        end else begin
          if (w) h = dc_q.pop_front();
          else   h = ic_q.pop_front();
          check("sb_fwd", {mem_read, mem_write, mem_addr[25:0], mem_wdata[99:0]},
                {h.rd & ~h.wr, h.wr, h.addr[25:0], h.wdata[99:0]});
          check("sb_addr_hi", 128'(mem_addr), 128'(h.addr));
        end
        if (mem_write) mem_store[mem_addr] = mem_wdata;
        done_log.push_back('{w, mem_addr});
      end
      prev_done = mem_ready & active;
    end
    prev_active = active;
    prev_ic_req = ic_mem_read | ic_mem_write;
    prev_dc_req = dc_mem_read | dc_mem_write;
  end

  task automatic drive(input logic id, input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    if (id) begin
      dc_mem_read = rd; dc_mem_write = wr; dc_mem_addr = a; dc_mem_wdata = wd;
    end else begin
      ic_mem_read = rd; ic_mem_write = wr; ic_mem_addr = a; ic_mem_wdata = wd;
    end
  endtask

  // Cache-side handshake: hold until ready, drop next cycle, check read data.
  task automatic cache_txn(input logic id, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    txn_t t;
    logic [DATA_W-1:0] exp_rd;
    int n = 0;
    t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd;
    if (id) dc_q.push_back(t);
    else    ic_q.push_back(t);
    drive(id, rd, wr, a, wd);
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? dc_mem_ready : ic_mem_ready) && n < 200);
    if (!(id ? dc_mem_ready : ic_mem_ready)) begin
      check(id ? "dc_ready_timeout" : "ic_ready_timeout", 128'(0), 128'(1));
      drive(id, 1'b0, 1'b0, '0, '0);
      return;
    end
    exp_rd = lookup(a);
    @(posedge clk);
    #1 drive(id, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    if (rd && !wr)
      check(id ? "dc_rdata" : "ic_rdata", id ? dc_mem_rdata : ic_mem_rdata, exp_rd);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int   n = 0;
    logic seen = 1'b0;
    fork
      cache_txn(v.id, v.rd, v.wr, v.addr, v.wdata);
      while (!seen && n < 60) begin
        @(negedge clk);
        n++;
        if (v.id ? dc_mem_ready : ic_mem_ready) begin
          seen = 1'b1;
          check(name, 128'({mem_read, mem_write, ic_mem_ready, dc_mem_ready}),
                128'({v.exp_read, v.exp_write, ~v.id, v.id}));
        end
      end
    join
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    proc_reset = 1'b0;
  endtask

  task automatic check_order(input string name, input int n, input logic [3:0] exp_ids);
    logic [3:0] got = '0;
    int sz = done_log.size();
    for (int i = 0; i < sz && i < 4; i++) got[i] = done_log[i].id;
    check(name, 128'({sz[7:0], got}), 128'({n[7:0], exp_ids}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  vec_t vecs[6];
  int   rd_cyc, icp, dcp, wcyc, werr, n;
  int   ic_done, dc_done;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h0000123, 128'h0,    1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 28'h0ABCDEF, 128'h0,    1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 28'h0000123, {4{32'h1234_5678}}, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 28'h0000055, {4{32'hCAFE_F00D}}, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 28'h0000099, {4{32'h0BAD_0BAD}}, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 28'h0000123, 128'h0,    1'b1, 1'b0};
    mem_store[28'h0000010] = {{15{8'hA5}}, 8'h01};

    // Reset state
    do_reset();
    check("reset_outs", 128'({mem_read, mem_write, |mem_addr, |mem_wdata,
                              ic_mem_ready, dc_mem_ready}), '0);
    check("reset_rdata", ic_mem_rdata | dc_mem_rdata, '0);

    // Lone I-cache read, 4-cycle memory latency
    mem_lat = 4; rd_cyc = 0; icp = 0; dcp = 0;
    fork
      cache_txn(1'b0, 1'b1, 1'b0, 28'h0000010, '0);
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (mem_read && mem_addr == 28'h0000010) rd_cyc++;
        if (ic_mem_ready) icp++;
        if (dc_mem_ready) dcp++;
      end
    join
    check("ic_alone_read_cycles", 128'(rd_cyc), 128'(5));
    check("ic_alone_ready_pulses", 128'({icp[7:0], dcp[7:0]}), 128'({8'd1, 8'd0}));

    // Directed single-transaction vectors (includes illegal read+write)
    mem_lat = 2;
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d_fwd", i), vecs[i]);

    // Simultaneous requests straight after reset
    do_reset(); done_log.delete();
    fork
      cache_txn(1'b0, 1'b1, 1'b0, 28'h0000020, '0);
      cache_txn(1'b1, 1'b1, 1'b0, 28'h0000040, '0);
    join
    check_order("sim_order", 2, 4'b0010);
    if (done_log.size() >= 2)
      check("sim_addrs", 128'({done_log[0].addr, done_log[1].addr}), 128'({28'h20, 28'h40}));

    // Back-to-back contention
    do_reset(); done_log.delete();
    fork
      begin
        cache_txn(1'b0, 1'b1, 1'b0, 28'h0000100, '0);
        cache_txn(1'b0, 1'b1, 1'b0, 28'h0000101, '0);
      end
      begin
        cache_txn(1'b1, 1'b1, 1'b0, 28'h0000200, '0);
        cache_txn(1'b1, 1'b1, 1'b0, 28'h0000201, '0);
      end
    join
    check_order("b2b_order", 4, 4'b1010);

    // D-cache write-back then allocate, I-cache read arriving in between
    do_reset(); done_log.delete(); wcyc = 0; werr = 0;
    fork
      begin
        cache_txn(1'b1, 1'b0, 1'b1, 28'h0000007, DEAD);
        cache_txn(1'b1, 1'b1, 1'b0, 28'h0000003, '0);
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_write && n < 20);
        cache_txn(1'b0, 1'b1, 1'b0, 28'h0000005, '0);
      end
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (mem_write) wcyc++;
        if ((mem_wdata == DEAD) != mem_write) werr++;
      end
    join
    check_order("wb_alloc_order", 3, 4'b0101);
    if (done_log.size() >= 3)
      check("wb_alloc_addrs", 128'({done_log[0].addr, done_log[1].addr, done_log[2].addr}),
            128'({28'h7, 28'h5, 28'h3}));
    check("wb_wdata_window", 128'({wcyc[7:0], werr[7:0]}), 128'({8'd3, 8'd0}));

    // Reset while D-cache is granted (rdata_q holds the last read here)
    mem_lat = 20;
    dc_mem_read = 1'b1; dc_mem_addr = 28'h0000044;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_read && n < 10);
    check("rst_grant_d_seen", 128'({mem_read, mem_addr}), 128'({1'b1, 28'h44}));
    proc_reset = 1'b1;
    @(negedge clk);
    check("rst_mem_outs", 128'({mem_read, mem_write, |mem_addr, |mem_wdata,
                                ic_mem_ready, dc_mem_ready}), '0);
    check("rst_rdata", dc_mem_rdata, '0);
    ic_mem_read = 1'b1; ic_mem_addr = 28'h0000066;
    proc_reset = 1'b0;
    @(negedge clk);
    check("rst_ic_first", 128'({mem_read, mem_addr}), 128'({1'b1, 28'h66}));
    mem_lat = 2;
    do_reset();

    // Randomized traffic from both caches
    done_log.delete(); rand_lat = 1'b1;
    fork
      for (int i = 0; i < 25; i++) begin
        logic wr_i;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        wr_i = ($urandom_range(0, 3) == 0);
        cache_txn(1'b0, ~wr_i, wr_i, 28'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom});
      end
      for (int i = 0; i < 25; i++) begin
        logic wr_d;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        wr_d = ($urandom_range(0, 1) == 0);
        cache_txn(1'b1, ~wr_d, wr_d, 28'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom});
      end
    join
    rand_lat = 1'b0;
    ic_done = 0; dc_done = 0;
    foreach (done_log[i]) if (done_log[i].id) dc_done++; else ic_done++;
    check("rand_counts", 128'({ic_done[7:0], dc_done[7:0]}), 128'({8'd25, 8'd25}));
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
